// File: rtl/serial_addr_arbiter.sv
// Round-robin arbiter sharing one serial address link (data + valid/ready) among 2..4 masters.
// Optional grant-to-first-beat watchdog enabled by defining ARB_TIMEOUT_EN.
module serial_addr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 12
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_data,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic                   s_valid,
  output logic                   s_data,
  input  logic                   s_ready,
  output logic                   busy,
  output logic [1:0]             owner,
  output logic                   timeout
);

  localparam int              CW        = $clog2(ADDR_WIDTH + 1);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(ADDR_WIDTH - 1);
  localparam logic [1:0]      PTR_RESET = 2'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER,
    RELEASE
  } state_t;

  state_t        state, state_next;
  logic [1:0]    owner_q, owner_next;
  logic [1:0]    ptr_q, ptr_next;
  logic [CW-1:0] beat_cnt, beat_cnt_next;

  logic          rr_found;
  logic [1:0]    rr_winner;
  int            rr_best;
  int            rr_dist;

  logic          own_valid;
  logic          own_data;
  logic          own_req;
  logic          beat;

`ifdef ARB_TIMEOUT_EN
  localparam int            WW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wait_cnt, wait_cnt_next;
  logic          timeout_q, timeout_next;
`endif

  // Select the owner's signals with constant indices so out-of-range owners read as zero.
  always_comb begin
    own_valid = 1'b0;
    own_data  = 1'b0;
    own_req   = 1'b0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (owner_q == 2'(j)) begin
        own_valid = m_valid[j];
        own_data  = m_data[j];
        own_req   = req[j];
      end
    end
  end

  assign busy    = (state == GRANT) || (state == XFER);
  assign s_valid = busy & own_valid;
  assign s_data  = busy & own_data;
  assign beat    = s_valid & s_ready;
  assign owner   = owner_q;

  always_comb begin
    grant   = '0;
    m_ready = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      grant[j]   = busy && (owner_q == 2'(j));
      m_ready[j] = busy && (owner_q == 2'(j)) && s_ready;
    end
  end

  // Winner is the requester with the smallest distance past the pointer.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = ptr_q;
    rr_best   = NUM_MASTERS;
    rr_dist   = 0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      rr_dist = (j + 2 * NUM_MASTERS - int'(ptr_q) - 1) % NUM_MASTERS;
      if (req[j] && (rr_dist < rr_best)) begin
        rr_best   = rr_dist;
        rr_winner = 2'(j);
        rr_found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state;
    owner_next    = owner_q;
    ptr_next      = ptr_q;
    beat_cnt_next = beat_cnt;
`ifdef ARB_TIMEOUT_EN
    wait_cnt_next = wait_cnt;
    timeout_next  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_next = GRANT;
          owner_next = rr_winner;
          ptr_next   = rr_winner;
        end
      end
      GRANT: begin
        if (beat) begin
          if (beat_cnt == LAST_BEAT) begin
            state_next    = RELEASE;
            beat_cnt_next = '0;
          end else begin
            state_next    = XFER;
            beat_cnt_next = beat_cnt + 1'b1;
          end
        end else if (!own_req) begin
          state_next = RELEASE;
`ifdef ARB_TIMEOUT_EN
        end else if (wait_cnt == WAIT_LAST) begin
          state_next   = RELEASE;
          timeout_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
`endif
        end
      end
      // Requests are ignored here: once started, a word always completes.
      XFER: begin
        if (beat) begin
          if (beat_cnt == LAST_BEAT) begin
            state_next    = RELEASE;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt + 1'b1;
          end
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
`ifdef ARB_TIMEOUT_EN
    if (state_next != GRANT) begin
      wait_cnt_next = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner_q  <= 2'd0;
      ptr_q    <= PTR_RESET;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      owner_q  <= owner_next;
      ptr_q    <= ptr_next;
      beat_cnt <= beat_cnt_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Revocation leaves the pointer on the revoked master so it drops to lowest priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt  <= wait_cnt_next;
      timeout_q <= timeout_next;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addr_arbiter.sv
// Directed self-checking bench for serial_addr_arbiter (NUM_MASTERS=2, ADDR_WIDTH=12).
// Exercises the timeout path when ARB_TIMEOUT_EN is defined, the req-drop exit otherwise.
module tb_serial_addr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] m_valid;
  logic [1:0] m_data;
  logic [1:0] m_ready;
  logic       s_valid;
  logic       s_data;
  logic       s_ready;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  int pass_count  = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  serial_addr_arbiter #(
    .NUM_MASTERS(2),
    .ADDR_WIDTH (12)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .grant  (grant),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_ready(m_ready),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .busy   (busy),
    .owner  (owner),
    .timeout(timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    req     = 2'b00;
    m_valid = 2'b00;
    m_data  = 2'b00;
    s_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    req     = 2'b00;
    m_valid = 2'b11;
    m_data  = 2'b11;
    s_ready = 1'b1;
    tick();
    tick();
    #1;
    check_count++;
    if (grant !== 2'b00) $display("[TB] FAIL reset_grant: got %b want 00", grant); else pass_count++;
    check_count++;
    if (m_ready !== 2'b00) $display("[TB] FAIL reset_m_ready: got %b want 00", m_ready); else pass_count++;
    check_count++;
    if (s_valid !== 1'b0) $display("[TB] FAIL reset_s_valid: got %b want 0", s_valid); else pass_count++;
    check_count++;
    if (s_data !== 1'b0) $display("[TB] FAIL reset_s_data: got %b want 0", s_data); else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else pass_count++;
    check_count++;
    if (owner !== 2'd0) $display("[TB] FAIL reset_owner: got %0d want 0", owner); else pass_count++;
    check_count++;
    if (timeout !== 1'b0) $display("[TB] FAIL reset_timeout: got %b want 0", timeout); else pass_count++;
    reset   = 1'b0;
    m_valid = 2'b00;
    m_data  = 2'b00;
  endtask

  task automatic test_single_word;
    logic [11:0] word;
    word    = 12'hB3A;
    req     = 2'b01;
    s_ready = 1'b1;
    #1;
    check_count++;
    if (grant !== 2'b00) $display("[TB] FAIL single_latency: got %b want 00", grant); else pass_count++;
    tick();
    check_count++;
    if (grant !== 2'b01) $display("[TB] FAIL single_grant: got %b want 01", grant); else pass_count++;
    check_count++;
    if (owner !== 2'd0) $display("[TB] FAIL single_owner: got %0d want 0", owner); else pass_count++;
    check_count++;
    if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b want 1", busy); else pass_count++;
    for (int b = 0; b < 12; b++) begin
      m_valid = 2'b01;
      m_data  = {~word[11-b], word[11-b]};
      if (b == 11) req = 2'b00;
      #1;
      check_count++;
      if (s_data !== word[11-b])
        $display("[TB] FAIL single_data_beat%0d: got %b want %b", b + 1, s_data, word[11-b]);
      else pass_count++;
      if (b == 0) begin
        check_count++;
        if (m_ready !== 2'b01) $display("[TB] FAIL single_m_ready: got %b want 01", m_ready); else pass_count++;
      end
      tick();
    end
    m_valid = 2'b00;
    #1;
    check_count++;
    if (grant !== 2'b00) $display("[TB] FAIL single_release_grant: got %b want 00", grant); else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL single_release_busy: got %b want 0", busy); else pass_count++;
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_g;
    int run;
    do_reset();
    req     = 2'b11;
    m_valid = 2'b11;
    m_data  = 2'b10;
    s_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check_count++;
      if (grant !== exp_g) $display("[TB] FAIL b2b_grant%0d: got %b want %b", k, grant, exp_g); else pass_count++;
      check_count++;
      if (s_data !== exp_g[1]) $display("[TB] FAIL b2b_data%0d: got %b want %b", k, s_data, exp_g[1]); else pass_count++;
      check_count++;
      if (m_ready !== exp_g) $display("[TB] FAIL b2b_m_ready%0d: got %b want %b", k, m_ready, exp_g); else pass_count++;
      run = 1;
      tick();
      while (grant === exp_g && run < 20) begin
        run++;
        tick();
      end
      check_count++;
      if (run !== 12) $display("[TB] FAIL b2b_length%0d: got %0d want 12", k, run); else pass_count++;
      check_count++;
      if (grant !== 2'b00) $display("[TB] FAIL b2b_gap_release%0d: got %b want 00", k, grant); else pass_count++;
      tick();
      check_count++;
      if (grant !== 2'b00) $display("[TB] FAIL b2b_gap_idle%0d: got %b want 00", k, grant); else pass_count++;
    end
    req     = 2'b00;
    m_valid = 2'b00;
  endtask

  task automatic test_stall;
    do_reset();
    req     = 2'b10;
    m_valid = 2'b11;
    m_data  = 2'b01;
    s_ready = 1'b1;
    tick();
    check_count++;
    if (grant !== 2'b10) $display("[TB] FAIL stall_grant: got %b want 10", grant); else pass_count++;
    repeat (4) tick();
    s_ready = 1'b0;
    req     = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_count++;
      if (m_ready !== 2'b00) $display("[TB] FAIL stall_m_ready%0d: got %b want 00", i, m_ready); else pass_count++;
      check_count++;
      if (grant !== 2'b10) $display("[TB] FAIL stall_grant%0d: got %b want 10", i, grant); else pass_count++;
      check_count++;
      if (s_valid !== 1'b1) $display("[TB] FAIL stall_s_valid%0d: got %b want 1", i, s_valid); else pass_count++;
      tick();
    end
    s_ready = 1'b1;
    #1;
    check_count++;
    if (m_ready !== 2'b10) $display("[TB] FAIL stall_resume_m_ready: got %b want 10", m_ready); else pass_count++;
    check_count++;
    if (s_data !== 1'b0) $display("[TB] FAIL stall_resume_data: got %b want 0", s_data); else pass_count++;
    repeat (7) tick();
    check_count++;
    if (grant !== 2'b10) $display("[TB] FAIL stall_beat12_grant: got %b want 10", grant); else pass_count++;
    tick();
    check_count++;
    if (grant !== 2'b00) $display("[TB] FAIL stall_release: got %b want 00", grant); else pass_count++;
    tick();
    check_count++;
    if (grant !== 2'b00) $display("[TB] FAIL stall_idle: got %b want 00", grant); else pass_count++;
    tick();
    check_count++;
    if (grant !== 2'b01) $display("[TB] FAIL stall_next_grant: got %b want 01", grant); else pass_count++;
    check_count++;
    if (owner !== 2'd0) $display("[TB] FAIL stall_next_owner: got %0d want 0", owner); else pass_count++;
    req     = 2'b00;
    m_valid = 2'b00;
  endtask

  task automatic test_reset_mid_transfer;
    do_reset();
    req     = 2'b01;
    m_valid = 2'b11;
    m_data  = 2'b11;
    s_ready = 1'b1;
    tick();
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check_count++;
    if (grant !== 2'b00) $display("[TB] FAIL midrst_grant: got %b want 00", grant); else pass_count++;
    check_count++;
    if (m_ready !== 2'b00) $display("[TB] FAIL midrst_m_ready: got %b want 00", m_ready); else pass_count++;
    check_count++;
    if (s_valid !== 1'b0) $display("[TB] FAIL midrst_s_valid: got %b want 0", s_valid); else pass_count++;
    check_count++;
    if (s_data !== 1'b0) $display("[TB] FAIL midrst_s_data: got %b want 0", s_data); else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else pass_count++;
    check_count++;
    if (timeout !== 1'b0) $display("[TB] FAIL midrst_timeout: got %b want 0", timeout); else pass_count++;
    reset = 1'b0;
    req   = 2'b10;
    tick();
    check_count++;
    if (grant !== 2'b10) $display("[TB] FAIL midrst_regrant: got %b want 10", grant); else pass_count++;
    check_count++;
    if (owner !== 2'd1) $display("[TB] FAIL midrst_owner: got %0d want 1", owner); else pass_count++;
    req     = 2'b00;
    m_valid = 2'b00;
    tick();
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    do_reset();
    req     = 2'b11;
    m_valid = 2'b00;
    s_ready = 1'b1;
    tick();
    check_count++;
    if (grant !== 2'b01) $display("[TB] FAIL to_grant: got %b want 01", grant); else pass_count++;
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_count++;
    if (n !== 16) $display("[TB] FAIL to_delay: got %0d want 16", n); else pass_count++;
    check_count++;
    if (grant !== 2'b00) $display("[TB] FAIL to_revoked: got %b want 00", grant); else pass_count++;
    tick();
    check_count++;
    if (timeout !== 1'b0) $display("[TB] FAIL to_pulse_width: got %b want 0", timeout); else pass_count++;
    tick();
    check_count++;
    if (grant !== 2'b10) $display("[TB] FAIL to_next_grant: got %b want 10", grant); else pass_count++;
    req = 2'b00;
  endtask
`else
  task automatic test_grant_req_drop;
    do_reset();
    req     = 2'b01;
    m_valid = 2'b00;
    s_ready = 1'b1;
    tick();
    check_count++;
    if (grant !== 2'b01) $display("[TB] FAIL drop_grant: got %b want 01", grant); else pass_count++;
    repeat (20) tick();
    check_count++;
    if (grant !== 2'b01) $display("[TB] FAIL drop_held: got %b want 01", grant); else pass_count++;
    check_count++;
    if (timeout !== 1'b0) $display("[TB] FAIL drop_no_timeout: got %b want 0", timeout); else pass_count++;
    req = 2'b00;
    tick();
    check_count++;
    if (grant !== 2'b00) $display("[TB] FAIL drop_release: got %b want 00", grant); else pass_count++;
    req = 2'b11;
    tick();
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL drop_idle_busy: got %b want 0", busy); else pass_count++;
    tick();
    check_count++;
    if (grant !== 2'b10) $display("[TB] FAIL drop_next_grant: got %b want 10", grant); else pass_count++;
    req = 2'b00;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    req     = 2'b00;
    m_valid = 2'b00;
    m_data  = 2'b00;
    s_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid_transfer();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_grant_req_drop();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/serial_addr_arbiter.md
# serial_addr_arbiter

Round-robin arbiter that shares one serial address link (one data wire plus valid/ready) between up to four transmitter state machines and a single receiver state machine. It grants one requester at a time and muxes that master's serial bit and valid onto the link. It routes the receiver's ready back only to the owner. Ownership is held for exactly one complete ADDR_WIDTH-bit word, then released. The block sits between the txdata-style transmitters and the addr-style receiver in the bus top level, on the same scaled clock.

## Interface
- NUM_MASTERS, 2: number of requesters, legal 2..4
- ADDR_WIDTH, 12: beats per transfer, one bit per beat
- TIMEOUT_CYCLES, 16: grant-to-first-valid limit, used only with ARB_TIMEOUT_EN

Ports:
- clk  in  1  scaled system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  NUM_MASTERS  per-master bus request
- grant  out  NUM_MASTERS  one-hot registered grant, all-zero when no owner
- m_valid  in  NUM_MASTERS  per-master beat valid
- m_data  in  NUM_MASTERS  per-master serial address bit
- m_ready  out  NUM_MASTERS  s_ready routed to the owner only, 0 to all others
- s_valid  out  1  owner's m_valid, 0 when not in XFER/GRANT
- s_data  out  1  owner's m_data, 0 when no owner
- s_ready  in  1  receiver ready
- busy  out  1  high in GRANT or XFER
- owner  out  2  index of current or last owner
- timeout  out  1  one-cycle pulse on grant revocation (tied 0 without ARB_TIMEOUT_EN)

## Operation
- States: IDLE, GRANT (owner selected, waiting for first beat), XFER (counting beats), RELEASE (one-cycle bus-turnaround gap).
- IDLE: if any req, pick the winner by round-robin, then go to GRANT. The search starts at the master after the pointer, and the pointer resets to NUM_MASTERS-1, so master 0 wins first. No req means stay in IDLE.
- On entry to GRANT: owner and grant update, and the pointer is set to the winner.
- Beat: any cycle with s_valid && s_ready. The beat counter (width clog2(ADDR_WIDTH+1)) increments per beat.
- GRANT → XFER on the first beat, with the counter at 1.
- GRANT → RELEASE if the owner drops req before its first beat.
- XFER → RELEASE on the beat that makes the count equal ADDR_WIDTH; the counter then clears.
- In XFER, valid without ready is a stall: no count, and the data must be held by the master. Dropping req in XFER is ignored; the word always completes.
- RELEASE → IDLE unconditionally, with grant all-zero.
- m_valid, m_data, and m_ready of non-owners never reach the link. Non-owners see m_ready=0.
- Out-of-range indices (≥ NUM_MASTERS) are never selected.

## Timing
- Reset values: grant=0, m_ready=0, s_valid=0, s_data=0, busy=0, owner=0, timeout=0. State is IDLE, counter 0, pointer NUM_MASTERS-1.
- Reset asserted mid-transfer aborts the transfer at the next edge with no completion signalled; the receiver must be reset alongside.
- Request latency: req high in IDLE at cycle t gives grant at t+1.
- The mux paths (s_valid, s_data, m_ready) are combinational from registered owner/state, with zero added latency.
- Final beat at cycle t: grant low at t+1 (RELEASE), IDLE at t+2, next grant earliest at t+3.
- Back-to-back requesters alternate: with both masters holding req, grants are 0,1,0,1…

## Configuration
- ARB_TIMEOUT_EN defined:
  - In GRANT, a wait counter counts cycles without a beat.
  - When it reaches TIMEOUT_CYCLES, the grant is revoked and the state goes to RELEASE.
  - timeout pulses high for that RELEASE cycle, and the pointer stays at the revoked master so it loses priority.
  - The counter clears on leaving GRANT.
- ARB_TIMEOUT_EN undefined: no wait counter. GRANT exits only on a first beat or on req drop, and timeout is constant 0.

## Test plan
- Reset, then req=01, master 0 sends 12 beats with s_ready=1 → grant=01 one cycle after req, s_data mirrors m_data[0] for 12 beats, grant=00 the cycle after beat 12.
- req=11 held, both always valid → grant sequence 01,10,01,10; each ownership exactly 12 beats; 2 idle cycles (RELEASE, IDLE) between final beat and next grant.
- Owner 1 in XFER, s_ready low for 5 cycles after beat 4 → count frozen at 4, m_ready[0]=0 throughout, transfer ends after beat 12 regardless of req[1] drop.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, master 0 granted, m_valid[0]=0 → timeout pulses 16 cycles after grant, grant cleared, master 1 (req high) granted next.
- reset pulsed at beat 7 of a transfer → next cycle all outputs at reset values, then req=10 → grant=10 (pointer back to reset, master 1 only requester).
